// File: rtl/axi_pkg.sv
// Shared AR state encodings, burst-type constants and the burst legality check
// for the AXI read protocol block.
package axi_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'b00,
    ASSERT = 2'b01,
    COMMIT = 2'b11
  } ar_state_e;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    return (burst == RSVD) ||
           ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/axi_read_protocol_if.sv
// Bus bundle between stimulus and the read protocol block: raw request/beat
// inputs plus the registered AXI-style AR/R outputs.
interface axi_read_protocol_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic [AW-1:0] araddr_in;
  logic [7:0]    arlen_in;
  logic [2:0]    arsize_in;
  logic [1:0]    arburst_in;
  logic          arvalid_in;
  logic          arready_in;
  logic [DW-1:0] rdata_in;
  logic [1:0]    rresp_in;
  logic          rvalid_in;
  logic          rready_in;

  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          axi_rlast;
  logic          proto_err;

  modport master (
    output araddr_in, arlen_in, arsize_in, arburst_in, arvalid_in, arready_in,
    output rdata_in, rresp_in, rvalid_in, rready_in,
    input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid, axi_rready, axi_rlast, proto_err
  );

  modport slave (
    input  araddr_in, arlen_in, arsize_in, arburst_in, arvalid_in, arready_in,
    input  rdata_in, rresp_in, rvalid_in, rready_in,
    output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid, axi_rready, axi_rlast, proto_err
  );
endinterface

// File: rtl/axi_rd_beat_cnt.sv
// Beat counter for the active read burst: captures arlen on the AR handshake and
// flags whether the beat about to be presented is the last one.
module axi_rd_beat_cnt (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       load,
  input  logic [7:0] len_in,
  input  logic       beat_hs,
  output logic       next_last
);

  logic [7:0] cnt_q;
  logic [7:0] len_q;
  logic [7:0] next_idx;

  // Index of the beat that would be loaded this edge.
  assign next_idx  = beat_hs ? (cnt_q + 8'd1) : cnt_q;
  assign next_last = (next_idx == len_q);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt_q <= 8'd0;
      len_q <= 8'd0;
    end else if (load) begin
      cnt_q <= 8'd0;
      len_q <= len_in;
    end else if (beat_hs && (cnt_q != len_q)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/axi_read_protocol.sv
// AXI read-channel protocol engine: registers AR requests through a
// WAIT/ASSERT/COMMIT handshake FSM and streams one outstanding burst of R beats.
module axi_read_protocol
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input logic              axi_aclk,
  input logic              axi_aresetn,
  axi_read_protocol_if.slave bus
);

  ar_state_e     state_q, state_d;
  logic          latch_ar;
  logic [AW-1:0] araddr_q;
  logic [7:0]    arlen_q;
  logic [2:0]    arsize_q;
  logic [1:0]    arburst_q;

  logic          r_active_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    rresp_q;
  logic          rvalid_q, rlast_q, rready_q, proto_err_q;
  logic          ar_hs, r_hs, r_done, beat_load, next_last;

  // COMMIT is the only state with arvalid and arready both high.
  assign ar_hs     = (state_q == COMMIT);
  assign r_hs      = rvalid_q & rready_q;
  assign r_done    = r_hs & rlast_q;
  assign beat_load = r_active_q & bus.rvalid_in & (~rvalid_q | r_hs) & ~r_done;

  always_comb begin
    state_d  = state_q;
    latch_ar = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (bus.arvalid_in) begin
          latch_ar = 1'b1;
          state_d  = (bus.arready_in && !r_active_q) ? COMMIT : ASSERT;
        end
      end
      ASSERT: begin
        if (bus.arready_in && !r_active_q) state_d = COMMIT;
      end
      COMMIT: begin
        // The burst just accepted makes r_active high, so a new request must wait.
        if (bus.arvalid_in) begin
          latch_ar = 1'b1;
          state_d  = ASSERT;
        end else begin
          state_d  = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= WAIT;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ar) begin
        araddr_q  <= bus.araddr_in;
        arlen_q   <= bus.arlen_in;
        arsize_q  <= bus.arsize_in;
        arburst_q <= bus.arburst_in;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_active_q  <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rready_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      rready_q <= bus.rready_in;
      if (ar_hs) begin
        r_active_q <= 1'b1;
        if (burst_illegal(arburst_q, arlen_q)) proto_err_q <= 1'b1;
      end
      if (r_done) begin
        r_active_q <= 1'b0;
        rvalid_q   <= 1'b0;
        rlast_q    <= 1'b0;
      end else if (beat_load) begin
        rdata_q  <= bus.rdata_in;
        rresp_q  <= bus.rresp_in;
        rvalid_q <= 1'b1;
        rlast_q  <= next_last;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  axi_rd_beat_cnt u_beat_cnt (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .load        (ar_hs),
    .len_in      (arlen_q),
    .beat_hs     (r_hs),
    .next_last   (next_last)
  );

  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arlen   = arlen_q;
  assign bus.axi_arsize  = arsize_q;
  assign bus.axi_arburst = arburst_q;
  assign bus.axi_arvalid = (state_q != WAIT);
  assign bus.axi_arready = (state_q == COMMIT);
  assign bus.axi_rdata   = rdata_q;
  assign bus.axi_rresp   = rresp_q;
  assign bus.axi_rvalid  = rvalid_q;
  assign bus.axi_rready  = rready_q;
  assign bus.axi_rlast   = rlast_q;
  assign bus.proto_err   = proto_err_q;

endmodule

// File: tb/tb_axi_read_protocol.sv
// Directed testbench for axi_read_protocol: one task per scenario with
// hand-computed expectations.
module tb_axi_read_protocol;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  logic axi_aclk    = 1'b0;
  logic axi_aresetn = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   beat_cnt    = 0;
  int   ar_cnt      = 0;
  logic [DW-1:0] hs_data [64];
  logic          hs_last [64];

  always #5 axi_aclk = ~axi_aclk;

  axi_read_protocol_if #(.AW(AW), .DW(DW)) bus ();

  axi_read_protocol #(.AW(AW), .DW(DW)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .bus         (bus)
  );

  // Log every handshake that will complete on the coming rising edge.
  always @(negedge axi_aclk) begin
    if (bus.axi_rvalid && bus.axi_rready) begin
      hs_data[beat_cnt[5:0]] <= bus.axi_rdata;
      hs_last[beat_cnt[5:0]] <= bus.axi_rlast;
      beat_cnt <= beat_cnt + 1;
    end
    if (bus.axi_arvalid && bus.axi_arready) ar_cnt <= ar_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.araddr_in  = '0;
    bus.arlen_in   = '0;
    bus.arsize_in  = '0;
    bus.arburst_in = INCR;
    bus.arvalid_in = 1'b0;
    bus.arready_in = 1'b0;
    bus.rdata_in   = '0;
    bus.rresp_in   = '0;
    bus.rvalid_in  = 1'b0;
    bus.rready_in  = 1'b0;
  endtask

  task automatic start_ar(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
    bus.araddr_in  = addr;
    bus.arlen_in   = len;
    bus.arsize_in  = 3'd3;
    bus.arburst_in = burst;
    bus.arvalid_in = 1'b1;
    bus.arready_in = 1'b1;
    bus.rvalid_in  = 1'b1;
    bus.rready_in  = 1'b1;
    tick();
    bus.arvalid_in = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.arvalid_in = 1'b1;
    bus.rvalid_in  = 1'b1;
    bus.rready_in  = 1'b1;
    tick();
    tick();
    vectors++; if (bus.axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", bus.axi_arvalid); end
    vectors++; if (bus.axi_arready !== 1'b0) begin miscompares++; $display("FAIL rst_arready: got %b want 0", bus.axi_arready); end
    vectors++; if (bus.axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", bus.axi_rvalid); end
    vectors++; if (bus.axi_rready !== 1'b0) begin miscompares++; $display("FAIL rst_rready: got %b want 0", bus.axi_rready); end
    vectors++; if (bus.axi_rlast !== 1'b0) begin miscompares++; $display("FAIL rst_rlast: got %b want 0", bus.axi_rlast); end
    vectors++; if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_proto_err: got %b want 0", bus.proto_err); end
    vectors++; if (bus.axi_araddr !== '0) begin miscompares++; $display("FAIL rst_araddr: got %h want 0", bus.axi_araddr); end
    vectors++; if (bus.axi_rdata !== '0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.axi_rdata); end
    idle_inputs();
    axi_aresetn = 1'b1;
    tick();
    vectors++; if (bus.axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL idle_arvalid: got %b want 0", bus.axi_arvalid); end
  endtask

  task automatic test_single_beat;
    int b0;
    int a0;
    b0 = beat_cnt;
    a0 = ar_cnt;
    bus.rdata_in = 64'hA5A5_0000_0000_0001;
    start_ar(32'h0000_1000, 8'd0, INCR);
    vectors++; if ({bus.axi_arvalid, bus.axi_arready} !== 2'b11) begin miscompares++; $display("FAIL single_commit: got %b want 11", {bus.axi_arvalid, bus.axi_arready}); end
    vectors++; if (bus.axi_araddr !== 32'h0000_1000) begin miscompares++; $display("FAIL single_araddr: got %h want 00001000", bus.axi_araddr); end
    tick();
    vectors++; if ({bus.axi_arvalid, bus.axi_arready} !== 2'b00) begin miscompares++; $display("FAIL single_ar_drop: got %b want 00", {bus.axi_arvalid, bus.axi_arready}); end
    tick();
    vectors++; if ({bus.axi_rvalid, bus.axi_rlast} !== 2'b11) begin miscompares++; $display("FAIL single_beat: got %b want 11", {bus.axi_rvalid, bus.axi_rlast}); end
    vectors++; if (bus.axi_rdata !== 64'hA5A5_0000_0000_0001) begin miscompares++; $display("FAIL single_rdata: got %h want a5a5000000000001", bus.axi_rdata); end
    tick();
    vectors++; if ({bus.axi_rvalid, bus.axi_rlast} !== 2'b00) begin miscompares++; $display("FAIL single_clear: got %b want 00", {bus.axi_rvalid, bus.axi_rlast}); end
    tick();
    tick();
    vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL single_beats: got %0d want 1", beat_cnt - b0); end
    vectors++; if (ar_cnt - a0 !== 1) begin miscompares++; $display("FAIL single_ar_count: got %0d want 1", ar_cnt - a0); end
  endtask

  task automatic test_rready_toggle;
    logic          exp_v [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic          exp_l [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] exp_d [8] = '{64'h100, 64'h101, 64'h101, 64'h103, 64'h103, 64'h105, 64'h105, 64'h105};
    logic [1:0]    exp_r [8] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1};
    int b0;
    b0 = beat_cnt;
    start_ar(32'h0000_2000, 8'd3, INCR);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.rdata_in  = 64'h100 + 64'(i);
      bus.rresp_in  = 2'(i);
      bus.rready_in = (i % 2 == 0);
      tick();
      vectors++; if (bus.axi_rvalid !== exp_v[i]) begin miscompares++; $display("FAIL toggle_rvalid[%0d]: got %b want %b", i, bus.axi_rvalid, exp_v[i]); end
      vectors++; if (bus.axi_rlast !== exp_l[i]) begin miscompares++; $display("FAIL toggle_rlast[%0d]: got %b want %b", i, bus.axi_rlast, exp_l[i]); end
      if (exp_v[i]) begin
        vectors++; if (bus.axi_rdata !== exp_d[i]) begin miscompares++; $display("FAIL toggle_rdata[%0d]: got %h want %h", i, bus.axi_rdata, exp_d[i]); end
        vectors++; if (bus.axi_rresp !== exp_r[i]) begin miscompares++; $display("FAIL toggle_rresp[%0d]: got %0d want %0d", i, bus.axi_rresp, exp_r[i]); end
      end
    end
    bus.rready_in = 1'b1;
    tick();
    vectors++; if (beat_cnt - b0 !== 4) begin miscompares++; $display("FAIL toggle_beats: got %0d want 4", beat_cnt - b0); end
    vectors++; if ({hs_last[b0], hs_last[b0+1], hs_last[b0+2], hs_last[b0+3]} !== 4'b0001) begin miscompares++; $display("FAIL toggle_last_pos: got %b want 0001", {hs_last[b0], hs_last[b0+1], hs_last[b0+2], hs_last[b0+3]}); end
    vectors++; if (hs_data[b0+2] !== 64'h103) begin miscompares++; $display("FAIL toggle_beat3: got %h want 103", hs_data[b0+2]); end
  endtask

  task automatic test_back_to_back;
    int b0;
    int a0;
    b0 = beat_cnt;
    a0 = ar_cnt;
    start_ar(32'h0000_3000, 8'd7, INCR);
    tick();
    bus.araddr_in  = 32'h0000_4000;
    bus.arlen_in   = 8'd0;
    bus.arvalid_in = 1'b1;
    tick();
    bus.arvalid_in = 1'b0;
    bus.araddr_in  = 32'h0000_DEAD;
    vectors++; if ({bus.axi_arvalid, bus.axi_arready} !== 2'b10) begin miscompares++; $display("FAIL b2b_assert: got %b want 10", {bus.axi_arvalid, bus.axi_arready}); end
    vectors++; if (bus.axi_araddr !== 32'h0000_4000) begin miscompares++; $display("FAIL b2b_latched: got %h want 00004000", bus.axi_araddr); end
    for (int j = 0; j < 8; j++) begin
      tick();
      vectors++; if ({bus.axi_arvalid, bus.axi_arready} !== 2'b10) begin miscompares++; $display("FAIL b2b_hold[%0d]: got %b want 10", j, {bus.axi_arvalid, bus.axi_arready}); end
    end
    vectors++; if (bus.axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_r_clear: got %b want 0", bus.axi_rvalid); end
    tick();
    vectors++; if ({bus.axi_arvalid, bus.axi_arready} !== 2'b11) begin miscompares++; $display("FAIL b2b_commit: got %b want 11", {bus.axi_arvalid, bus.axi_arready}); end
    vectors++; if (bus.axi_araddr !== 32'h0000_4000) begin miscompares++; $display("FAIL b2b_addr_stable: got %h want 00004000", bus.axi_araddr); end
    tick();
    vectors++; if (bus.axi_arready !== 1'b0) begin miscompares++; $display("FAIL b2b_arready_drop: got %b want 0", bus.axi_arready); end
    tick();
    tick();
    tick();
    vectors++; if (beat_cnt - b0 !== 9) begin miscompares++; $display("FAIL b2b_beats: got %0d want 9", beat_cnt - b0); end
    vectors++; if ({hs_last[b0+6], hs_last[b0+7], hs_last[b0+8]} !== 3'b011) begin miscompares++; $display("FAIL b2b_last_pos: got %b want 011", {hs_last[b0+6], hs_last[b0+7], hs_last[b0+8]}); end
    vectors++; if (ar_cnt - a0 !== 2) begin miscompares++; $display("FAIL b2b_ar_count: got %0d want 2", ar_cnt - a0); end
  endtask

  task automatic test_wrap_err;
    int b0;
    b0 = beat_cnt;
    start_ar(32'h0000_5000, 8'd3, WRAP);
    for (int k = 0; k < 8; k++) tick();
    vectors++; if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL wrap4_err: got %b want 0", bus.proto_err); end
    vectors++; if (beat_cnt - b0 !== 4) begin miscompares++; $display("FAIL wrap4_beats: got %0d want 4", beat_cnt - b0); end
    b0 = beat_cnt;
    start_ar(32'h0000_6000, 8'd5, WRAP);
    vectors++; if (bus.proto_err !== 1'b0) begin miscompares++; $display("FAIL wrap6_err_early: got %b want 0", bus.proto_err); end
    tick();
    vectors++; if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL wrap6_err: got %b want 1", bus.proto_err); end
    for (int k = 0; k < 9; k++) tick();
    vectors++; if (beat_cnt - b0 !== 6) begin miscompares++; $display("FAIL wrap6_beats: got %0d want 6", beat_cnt - b0); end
    vectors++; if ({hs_last[b0+4], hs_last[b0+5]} !== 2'b01) begin miscompares++; $display("FAIL wrap6_last_pos: got %b want 01", {hs_last[b0+4], hs_last[b0+5]}); end
    vectors++; if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL wrap6_sticky: got %b want 1", bus.proto_err); end
  endtask

  task automatic test_reset_midburst;
    int b0;
    b0 = beat_cnt;
    start_ar(32'h0000_7000, 8'd7, INCR);
    for (int k = 0; k < 4; k++) tick();
    vectors++; if (bus.axi_rvalid !== 1'b1) begin miscompares++; $display("FAIL mid_rvalid_pre: got %b want 1", bus.axi_rvalid); end
    #1;
    axi_aresetn = 1'b0;
    #1;
    vectors++; if ({bus.axi_arvalid, bus.axi_arready, bus.axi_rvalid, bus.axi_rready, bus.axi_rlast, bus.proto_err} !== 6'b0) begin miscompares++; $display("FAIL mid_rst_flags: got %b want 000000", {bus.axi_arvalid, bus.axi_arready, bus.axi_rvalid, bus.axi_rready, bus.axi_rlast, bus.proto_err}); end
    vectors++; if (bus.axi_rdata !== '0) begin miscompares++; $display("FAIL mid_rst_rdata: got %h want 0", bus.axi_rdata); end
    vectors++; if (bus.axi_araddr !== '0) begin miscompares++; $display("FAIL mid_rst_araddr: got %h want 0", bus.axi_araddr); end
    tick();
    tick();
    axi_aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++; if (bus.axi_rvalid !== 1'b0) begin miscompares++; $display("FAIL mid_no_beat[%0d]: got %b want 0", k, bus.axi_rvalid); end
    end
    vectors++; if (beat_cnt - b0 !== 2) begin miscompares++; $display("FAIL mid_beats: got %0d want 2", beat_cnt - b0); end
  endtask

  task automatic test_reserved_burst;
    int b0;
    b0 = beat_cnt;
    start_ar(32'h0000_8000, 8'd0, RSVD);
    tick();
    vectors++; if (bus.proto_err !== 1'b1) begin miscompares++; $display("FAIL rsvd_err: got %b want 1", bus.proto_err); end
    for (int k = 0; k < 3; k++) tick();
    vectors++; if (beat_cnt - b0 !== 1) begin miscompares++; $display("FAIL rsvd_beats: got %0d want 1", beat_cnt - b0); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_rready_toggle();
    test_back_to_back();
    test_wrap_err();
    test_reset_midburst();
    test_reserved_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_read_protocol.md
AXI_READ_PROTOCOL -- requirements
Module: axi_read_protocol

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 64: read data width.
REQ-003 axi_aclk  in  1  the only clock; all state changes on its rising edge.
REQ-004 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 araddr_in/arlen_in/arsize_in/arburst_in  in  AW/8/3/2  request payload from stimulus.
REQ-006 arvalid_in  in  1  stimulus requests a read burst.
REQ-007 arready_in  in  1  slave-side willingness to accept an address.
REQ-008 rdata_in/rresp_in  in  DW/2  slave beat payload.
REQ-009 rvalid_in  in  1  slave has a beat available.
REQ-010 rready_in  in  1  master willingness to accept a beat.
REQ-011 axi_araddr/axi_arlen/axi_arsize/axi_arburst  out  AW/8/3/2  registered AR payload.
REQ-012 axi_arvalid, axi_arready  out  1  registered AR handshake pair.
REQ-013 axi_rdata/axi_rresp  out  DW/2  registered R payload.
REQ-014 axi_rvalid, axi_rready, axi_rlast  out  1  registered R handshake and last-beat flag.
REQ-015 proto_err  out  1  sticky flag for an illegal accepted request.

Function
REQ-016 AR handshake = edge with axi_arvalid & axi_arready; R handshake = edge with axi_rvalid & axi_rready.
REQ-017 AR FSM states: WAIT (arvalid 0), ASSERT (arvalid 1, arready 0), COMMIT (arvalid 1, arready 1).
REQ-018 WAIT: on arvalid_in, latch payload, set axi_arvalid next cycle; go COMMIT if arready_in & !r_active, else ASSERT.
REQ-019 ASSERT: payload and axi_arvalid held stable; go COMMIT, arready 1, when arready_in & !r_active.
REQ-020 COMMIT: handshake occurs; set r_active, load beat counter 0, capture arlen; arready 0; if arvalid_in, latch new payload and go ASSERT, else arvalid 0, go WAIT.
REQ-021 Only one burst outstanding: axi_arready never 1 while r_active is 1.
REQ-022 R path active only while r_active; rvalid_in ignored otherwise.
REQ-023 When axi_rvalid is 0, or an R handshake occurs this edge, and rvalid_in is 1: load rdata_in/rresp_in, axi_rvalid 1, axi_rlast = (next beat index == captured arlen).
REQ-024 Without handshake, axi_rvalid, axi_rdata, axi_rresp, axi_rlast hold stable.
REQ-025 axi_rready is rready_in registered each cycle.
REQ-026 Each R handshake increments the 8-bit beat counter; handshake with axi_rlast 1 clears r_active, axi_rvalid and axi_rlast next cycle unless a new beat of a new burst is already loaded (never same cycle).
REQ-027 Burst length = arlen+1 beats (1..256); counter never wraps within a burst.
REQ-028 Simultaneous last-beat handshake and pending arvalid_in: arready may assert the cycle after r_active clears, not earlier.
REQ-029 proto_err sets on AR handshake when arburst = 2'b11, or arburst = WRAP with arlen not in {1,3,7,15}; burst still executes.
REQ-030 rresp_in passed through unmodified; nonzero rresp does not end the burst early.

Reset
REQ-031 On axi_aresetn low, immediately: all valid/ready/rlast 0, payload outputs 0, proto_err 0, r_active 0, counter 0, FSM WAIT.
REQ-032 Reset mid-burst abandons the burst; no beat or rlast emitted after release until a new AR handshake.
REQ-033 First state change only on the first rising edge with axi_aresetn high.

Structure
REQ-034 Shared package axi_pkg holds WAIT/COMMIT/ASSERT state encodings and burst-type constants FIXED/INCR/WRAP.
REQ-035 Sub-module axi_rd_beat_cnt holds beat counter, captured arlen, and last-beat compare.

Verification
REQ-036 arlen=0, arready_in/rvalid_in/rready_in held 1 -> one AR handshake, one beat with rlast 1, r_active clears after it.
REQ-037 arlen=3, rready_in toggling 1,0,1,0 -> four beats, each stable while rready 0, rlast only on beat 4.
REQ-038 arvalid_in during active arlen=7 burst -> axi_arvalid 1, arready 0 until the cycle after beat-8 handshake.
REQ-039 arburst=WRAP, arlen=5 -> proto_err 1 after handshake, six beats still delivered.
REQ-040 axi_aresetn low after beat 2 of arlen=7 -> all outputs 0 immediately, no further beats after release.
